mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port, variable-latency memory between the instruction-fetch port and the load/store port of the RV32I core. It performs request arbitration, byte-lane alignment of stores, and extraction plus sign/zero extension of loads, using the `mem_rw`/`mem_size`/`mem_sign` encoding produced by `control`. It drives a pipeline `stall` while any accepted request is outstanding.

## Interface
- `STARVE_MAX`, default 4: number of consecutive data-port wins while fetch is waiting before fetch is forced to win.
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request; held until `if_valid`.
- `if_addr` in 32: fetch address; bits [1:0] ignored.
- `if_rdata` out 32: fetched instruction word.
- `if_valid` out 1: one-cycle completion pulse for fetch.
- `d_req` in 1: load/store request; held until `d_valid`.
- `d_rw` in 1: 0 = load, 1 = store.
- `d_addr` in 32: byte address.
- `d_wdata` in 32: store data, right-justified.
- `d_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `d_sign` in 1: 1 = sign-extend load, 0 = zero-extend.
- `d_rdata` out 32: extended load data; 0 for stores and faults.
- `d_valid` out 1: one-cycle completion pulse for data.
- `misalign` out 1: valid only with `d_valid`; 1 = access rejected.
- `m_req` out 1: memory request; held until `m_ready` is sampled.
- `m_we` out 1: memory write enable.
- `m_addr` out 32: word address, with {d_addr[31:2], 2'b00} or {if_addr[31:2], 2'b00}.
- `m_wdata` out 32: lane-replicated store data.
- `m_be` out 4: byte enables; 0000 on reads.
- `m_ready` in 1: memory accepts or completes the request this cycle.
- `m_rdata` in 32: read data, valid in the cycle `m_ready` = 1.
- `stall` out 1: (if_req & ~if_valid) | (d_req & ~d_valid); combinational.

## Operation
- FSM states:
  - IDLE: arbitrate.
    - Data wins if `d_req`, unless the starvation counter is at STARVE_MAX and `if_req` is high.
    - Granted data goes to FAULT if misaligned, otherwise to BUSY_D.
    - Granted fetch goes to BUSY_IF.
    - No request: stay in IDLE.
  - BUSY_IF / BUSY_D: `m_req` = 1 with all `m_*` outputs registered and stable. On an edge with `m_ready` = 1, latch the response, pulse the matching valid, and return to IDLE.
  - FAULT: pulse `d_valid` with `misalign` = 1 and `d_rdata` = 0; return to IDLE. No memory access occurs.
- Misaligned access:
  - Half with d_addr[0] = 1.
  - Word with d_addr[1:0] ≠ 00.
  - Any access with `d_size` = 11.
- Store byte enables: byte 0001<<a, half 0011<<a, word 1111, where a = d_addr[1:0].
- Store write data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load extraction:
  - s = m_rdata >> (8·a).
  - Byte: s[7:0] extended to 32 bits per `d_sign`.
  - Half: s[15:0] extended per `d_sign`.
  - Word: s unchanged.
- Starvation counter (3 bits minimum, saturating at STARVE_MAX):
  - Increments on each data grant while `if_req` = 1.
  - Clears on each fetch grant.
- Requester drops its request before completion: the transaction still completes and the valid still pulses. The next arbitration uses current inputs.
- Back-to-back: the valid cycle is spent in IDLE. A request still asserted in that cycle is arbitrated in it, including the same port re-requesting.

## Timing
- Reset values:
  - State IDLE; starvation counter 0.
  - `m_req`, `m_we`, `m_be`, `m_addr`, `m_wdata` all 0.
  - `if_valid`, `d_valid`, `misalign` 0.
  - `if_rdata`, `d_rdata` 0.
- Reset asserted mid-transaction: `m_req` drops asynchronously; the transaction is abandoned with no valid pulse.
- Latency, request seen at edge N:
  - `m_req` high after edge N.
  - `m_ready` sampled high at edge N+k (k ≥ 1) → valid high for the cycle after edge N+k.
  - Minimum 2 cycles request-to-valid; misalign 2 cycles (IDLE → FAULT → valid).
- `m_addr`, `m_we`, `m_be`, `m_wdata` do not change while `m_req` = 1 and `m_ready` = 0.
- `if_valid` and `d_valid` are never high in the same cycle.

## Test plan
- Load byte, signed: mem[0x100] = 0x80FF7F01, d_addr = 0x102, size 00, sign 1, `m_ready` tied 1 → `m_be` = 0000, `d_rdata` = 0xFFFFFFFF, `d_valid` exactly 2 cycles after request.
- Store half: d_addr = 0x206, d_wdata = 0x1234ABCD, size 01, `m_ready` high after 3 wait cycles → `m_addr` = 0x204, `m_be` = 1100, `m_wdata` = 0xABCDABCD held stable throughout, `d_valid` 1 cycle after `m_ready`.
- Misalign: word load at 0x103 → no `m_req`, `d_valid` = 1 with `misalign` = 1, `d_rdata` = 0 in the cycle after FAULT.
- Contention: `if_req` and `d_req` held continuously, STARVE_MAX = 4 → grant order D, D, D, D, IF, D…; counter clears after the IF grant.
- Unsigned half load: mem word 0x8001FFFE at 0x300, d_addr = 0x302, sign 0 → `d_rdata` = 0x00008001.
- `rst_n` low while in BUSY_D with `m_ready` = 0 → `m_req` = 0 immediately, no `d_valid`; after release, the FSM is in IDLE and re-arbitrates the still-held request.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, variable-latency memory between the
// instruction-fetch port and the load/store port. Stores are lane-aligned
// and replicated; loads are shifted down and sign/zero extended. A bounded
// starvation counter guarantees fetch progress under continuous data traffic.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    input  logic        d_sign,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        misalign,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        stall
);

    localparam int CNT_W = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, FAULT} state_t;

    state_t             state;
    logic [CNT_W-1:0]   starve_cnt;
    logic [1:0]         lane_q;
    logic [1:0]         size_q;
    logic               sign_q;
    logic               rw_q;
    logic               at_max;
    logic               grant_d;
    logic               d_mis;
    logic               unused_addr_bits;

    // Size 11 is never legal; halves need an even address, words full alignment.
    function automatic logic is_misaligned(input logic [1:0] a, input logic [1:0] size);
        logic r;
        case (size)
            2'b00:   r = 1'b0;
            2'b01:   r = a[0];
            2'b10:   r = |a;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] a, input logic [1:0] size);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = 4'b0011 << a;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicating the right-justified data puts it in every lane the enables may select.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] r;
        case (size)
            2'b00:   r = {4{wd[7:0]}};
            2'b01:   r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_data(input logic [31:0] rd, input logic [1:0] a,
                                              input logic [1:0] size, input logic sgn);
        logic        [31:0] s;
        logic signed [31:0] ext;
        s = rd >> {a, 3'b000};
        case (size)
            2'b00:   ext = sgn ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
            2'b01:   ext = sgn ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
            default: ext = s;
        endcase
        return ext;
    endfunction

    // Only the word part of the fetch address reaches memory.
    assign unused_addr_bits = ^if_addr[1:0];

    assign at_max  = (starve_cnt == CNT_W'(STARVE_MAX));
    assign grant_d = d_req & ~(if_req & at_max);
    assign d_mis   = is_misaligned(d_addr[1:0], d_size);

    // Pipeline hold: a requester is stalled until its own completion pulse.
    assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

    // Arbitration FSM with registered memory-side and completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            lane_q     <= 2'b00;
            size_q     <= 2'b00;
            sign_q     <= 1'b0;
            rw_q       <= 1'b0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= 32'h0;
            m_wdata    <= 32'h0;
            m_be       <= 4'b0000;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            misalign   <= 1'b0;
            if_rdata   <= 32'h0;
            d_rdata    <= 32'h0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        if (if_req && !at_max)
                            starve_cnt <= starve_cnt + 1'b1;
                        lane_q <= d_addr[1:0];
                        size_q <= d_size;
                        sign_q <= d_sign;
                        rw_q   <= d_rw;
                        if (d_mis) begin
                            state <= FAULT;
                        end else begin
                            state   <= BUSY_D;
                            m_req   <= 1'b1;
                            m_we    <= d_rw;
                            m_addr  <= {d_addr[31:2], 2'b00};
                            m_be    <= d_rw ? store_be(d_addr[1:0], d_size) : 4'b0000;
                            m_wdata <= d_rw ? store_data(d_size, d_wdata) : 32'h0;
                        end
                    end else if (if_req) begin
                        state      <= BUSY_IF;
                        starve_cnt <= '0;
                        m_req      <= 1'b1;
                        m_we       <= 1'b0;
                        m_addr     <= {if_addr[31:2], 2'b00};
                        m_be       <= 4'b0000;
                        m_wdata    <= 32'h0;
                    end
                end
                BUSY_IF: begin
                    if (m_ready) begin
                        m_req    <= 1'b0;
                        m_we     <= 1'b0;
                        m_be     <= 4'b0000;
                        if_rdata <= m_rdata;
                        if_valid <= 1'b1;
                        state    <= IDLE;
                    end
                end
                BUSY_D: begin
                    if (m_ready) begin
                        m_req   <= 1'b0;
                        m_we    <= 1'b0;
                        m_be    <= 4'b0000;
                        d_rdata <= rw_q ? 32'h0 : load_data(m_rdata, lane_q, size_q, sign_q);
                        d_valid <= 1'b1;
                        state   <= IDLE;
                    end
                end
                FAULT: begin
                    d_valid  <= 1'b1;
                    misalign <= 1'b1;
                    d_rdata  <= 32'h0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a memory responder with programmable wait states,
// a transaction-level expectation queue built from the access rules, and a
// negedge checker comparing every completion and memory handshake.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_rw;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic        d_sign;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        misalign;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        stall;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_sign(d_sign), .d_rdata(d_rdata), .d_valid(d_valid),
        .misalign(misalign),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_ready(m_ready), .m_rdata(m_rdata), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          mis;
        logic [31:0] rdata;
        bit          has_mem;
        logic [31:0] addr;
        bit          we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;

    exp_t        cq[$];
    exp_t        mq[$];
    logic [31:0] mem [logic [31:0]];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          wait_cycles = 0;
    int          wcnt = 0;

    int          res_lat;
    logic [31:0] res_rd;
    logic        res_mis;
    bit          res_saw;
    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memrd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    endfunction

    function automatic bit m_mis(input int a, input logic [1:0] size);
        int nb;
        nb = nbytes(size);
        return (nb == 0) || ((a % nb) != 0);
    endfunction

    function automatic logic [3:0] m_be_of(input int a, input logic [1:0] size);
        logic [3:0] be;
        int nb;
        nb = nbytes(size);
        for (int i = 0; i < 4; i++) be[i] = (i >= a) && (i < a + nb);
        return be;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] r;
        int nb;
        nb = nbytes(size);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_ld(input logic [31:0] w, input int a,
                                         input logic [1:0] size, input bit sgn);
        logic [31:0] v;
        logic [31:0] mask;
        int nb;
        nb   = nbytes(size);
        v    = w >> (8 * a);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        v    = v & mask;
        if (sgn && nb < 4 && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic exp_t mk_exp(input bit is_d, input bit rw, input logic [31:0] addr,
                                    input logic [31:0] wd, input logic [1:0] size, input bit sgn);
        exp_t e;
        int a;
        a         = int'(addr[1:0]);
        e.is_d    = is_d;
        e.addr    = {addr[31:2], 2'b00};
        e.mis     = is_d ? m_mis(a, size) : 1'b0;
        e.has_mem = !e.mis;
        e.we      = is_d && rw;
        e.be      = e.we ? m_be_of(a, size) : 4'b0000;
        e.wdata   = e.we ? m_wd(size, wd) : 32'h0;
        if (!is_d)               e.rdata = memrd(e.addr);
        else if (e.mis || rw)    e.rdata = 32'h0;
        else                     e.rdata = m_ld(memrd(e.addr), a, size, sgn);
        return e;
    endfunction

    function automatic void push_exp(input exp_t e);
        cq.push_back(e);
        if (e.has_mem) mq.push_back(e);
    endfunction

    // Memory responder: holds m_ready low for wait_cycles cycles of each request.
    initial begin
        m_ready = 1'b0;
        m_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (m_req) begin
                if (wcnt >= wait_cycles) begin
                    m_ready = 1'b1;
                    m_rdata = memrd(m_addr);
                end else begin
                    m_ready = 1'b0;
                    m_rdata = 32'h0;
                    wcnt++;
                end
            end else begin
                m_ready = 1'b0;
                m_rdata = 32'h0;
                wcnt    = 0;
            end
        end
    end

    // Checker: combinational stall, exclusive valids, held memory fields, handshakes, completions.
    logic        prev_wait = 1'b0;
    logic [68:0] prev_fields = '0;
    initial begin
        exp_t e;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            chk("stall", 32'(stall), 32'((if_req & ~if_valid) | (d_req & ~d_valid)));
            if (if_valid && d_valid) chk("valid_exclusive", 32'd1, 32'd0);
            if (prev_wait && m_req) begin
                n_cmp++;
                if ({m_addr, m_we, m_be, m_wdata} !== prev_fields) begin
                    n_fail++;
                    $display("FAIL m_hold: got %h, expected %h", {m_addr, m_we, m_be, m_wdata}, prev_fields);
                end
            end
            prev_wait   = m_req && !m_ready;
            prev_fields = {m_addr, m_we, m_be, m_wdata};
            if (m_req && m_ready && rst_n) begin
                if (mq.size() == 0) begin
                    chk("unexpected_mem_txn", m_addr, 32'hFFFF_FFFF);
                end else begin
                    e = mq.pop_front();
                    chk("m_addr", m_addr, e.addr);
                    chk("m_we", 32'(m_we), 32'(e.we));
                    chk("m_be", 32'(m_be), 32'(e.be));
                    if (e.we) begin
                        chk("m_wdata", m_wdata, e.wdata);
                        w = memrd(m_addr);
                        for (int i = 0; i < 4; i++)
                            if (m_be[i]) w[8*i +: 8] = m_wdata[8*i +: 8];
                        mem[m_addr] = w;
                    end
                end
            end
            if (if_valid || d_valid) begin
                if (cq.size() == 0) begin
                    chk("unexpected_valid", 32'({if_valid, d_valid}), 32'd0);
                end else begin
                    e = cq.pop_front();
                    chk("valid_port", 32'(d_valid), 32'(e.is_d));
                    if (d_valid) begin
                        chk("d_rdata", d_rdata, e.rdata);
                        chk("misalign", 32'(misalign), 32'(e.mis));
                    end else begin
                        chk("if_rdata", if_rdata, e.rdata);
                    end
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_m_req"}, 32'(m_req), 32'd0);
        chk({tag, "_m_we"}, 32'(m_we), 32'd0);
        chk({tag, "_m_be"}, 32'(m_be), 32'd0);
        chk({tag, "_m_addr"}, m_addr, 32'd0);
        chk({tag, "_m_wdata"}, m_wdata, 32'd0);
        chk({tag, "_valids"}, 32'({if_valid, d_valid, misalign}), 32'd0);
        chk({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    endtask

    // One request on one port, held until its valid; records latency and captures.
    task automatic run_one(input bit is_d, input bit rw, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [1:0] size, input bit sgn,
                           input int wt);
        bit done;
        push_exp(mk_exp(is_d, rw, addr, wd, size, sgn));
        wait_cycles = wt;
        @(posedge clk);
        #1;
        if (is_d) begin
            d_req = 1'b1; d_rw = rw; d_addr = addr; d_wdata = wd; d_size = size; d_sign = sgn;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        res_lat = 0; res_saw = 1'b0; done = 1'b0;
        repeat (60) begin
            @(posedge clk);
            #1;
            res_lat++;
            if (m_req && !res_saw) begin
                res_saw = 1'b1; cap_addr = m_addr; cap_be = m_be; cap_wdata = m_wdata;
            end
            if (is_d ? d_valid : if_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("timeout_valid", 32'd0, 32'd1);
        res_rd  = is_d ? d_rdata : if_rdata;
        res_mis = misalign;
        d_req   = 1'b0;
        if_req  = 1'b0;
    endtask

    initial begin
        string exp_order;
        string got_order;
        int    cnt;
        bit    done;
        rst_n = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_rw = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_size = 2'b00; d_sign = 1'b0;
        mem[32'h100] = 32'h80FF_7F01;
        mem[32'h300] = 32'h8001_FFFE;
        mem[32'h400] = 32'h1122_3344;
        mem[32'h500] = 32'h00A0_0093;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;

        // Hand-computed pins on the reference functions.
        chk("pin_be_half", 32'(m_be_of(2, 2'b01)), 32'h0000_000C);
        chk("pin_wd_half", m_wd(2'b01, 32'h1234_ABCD), 32'hABCD_ABCD);
        chk("pin_ld_sbyte", m_ld(32'h80FF_7F01, 2, 2'b00, 1'b1), 32'hFFFF_FFFF);
        chk("pin_mis_word", 32'(m_mis(3, 2'b10)), 32'd1);

        // Signed byte load, memory always ready.
        run_one(1'b1, 1'b0, 32'h102, 32'h0, 2'b00, 1'b1, 0);
        chk("lb_lat", res_lat, 32'd2);
        chk("lb_rdata", res_rd, 32'hFFFF_FFFF);
        chk("lb_be", 32'(cap_be), 32'd0);

        // Half store with three wait states.
        run_one(1'b1, 1'b1, 32'h206, 32'h1234_ABCD, 2'b01, 1'b0, 3);
        chk("sh_lat", res_lat, 32'd5);
        chk("sh_addr", cap_addr, 32'h204);
        chk("sh_be", 32'(cap_be), 32'h0000_000C);
        chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        chk("sh_mem", memrd(32'h204), 32'hABCD_0000);
        chk("sh_rdata", res_rd, 32'h0);

        // Misaligned word load.
        run_one(1'b1, 1'b0, 32'h103, 32'h0, 2'b10, 1'b0, 0);
        chk("mis_lat", res_lat, 32'd2);
        chk("mis_flag", 32'(res_mis), 32'd1);
        chk("mis_rdata", res_rd, 32'h0);
        chk("mis_no_mreq", 32'(res_saw), 32'd0);

        // Unsigned and signed half loads, byte loads from the top lane.
        run_one(1'b1, 1'b0, 32'h302, 32'h0, 2'b01, 1'b0, 0);
        chk("lhu_rdata", res_rd, 32'h0000_8001);
        run_one(1'b1, 1'b0, 32'h300, 32'h0, 2'b01, 1'b1, 2);
        chk("lh_rdata", res_rd, 32'hFFFF_FFFE);
        run_one(1'b1, 1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 0);
        chk("lbu_rdata", res_rd, 32'h0000_0080);
        run_one(1'b1, 1'b0, 32'h103, 32'h0, 2'b00, 1'b1, 1);
        chk("lb3_rdata", res_rd, 32'hFFFF_FF80);

        // Byte and word stores, illegal size, odd half.
        run_one(1'b1, 1'b1, 32'h211, 32'hDEAD_BE55, 2'b00, 1'b0, 0);
        chk("sb_be", 32'(cap_be), 32'h0000_0002);
        chk("sb_wdata", cap_wdata, 32'h5555_5555);
        run_one(1'b1, 1'b1, 32'h220, 32'hCAFE_F00D, 2'b10, 1'b0, 1);
        chk("sw_be", 32'(cap_be), 32'h0000_000F);
        chk("sw_mem", memrd(32'h220), 32'hCAFE_F00D);
        run_one(1'b1, 1'b0, 32'h300, 32'h0, 2'b11, 1'b0, 0);
        chk("size11_mis", 32'(res_mis), 32'd1);
        run_one(1'b1, 1'b0, 32'h301, 32'h0, 2'b01, 1'b0, 0);
        chk("half_odd_mis", 32'(res_mis), 32'd1);

        // Fetch with one wait state; address low bits dropped.
        run_one(1'b0, 1'b0, 32'h503, 32'h0, 2'b00, 1'b0, 1);
        chk("if_lat", res_lat, 32'd3);
        chk("if_addr", cap_addr, 32'h500);
        chk("if_rdata_lit", res_rd, 32'h00A0_0093);

        // Contention: both ports held for ten completions.
        exp_order = "";
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (cnt == STARVE_MAX) begin
                exp_order = {exp_order, "I"};
                cnt = 0;
                push_exp(mk_exp(1'b0, 1'b0, 32'h500, 32'h0, 2'b00, 1'b0));
            end else begin
                exp_order = {exp_order, "D"};
                cnt = (cnt + 1 > STARVE_MAX) ? STARVE_MAX : cnt + 1;
                push_exp(mk_exp(1'b1, 1'b0, 32'h400, 32'h0, 2'b10, 1'b0));
            end
        end
        n_cmp++;
        if (exp_order != "DDDDIDDDDI") begin
            n_fail++;
            $display("FAIL pin_order: got %s, expected DDDDIDDDDI", exp_order);
        end
        wait_cycles = 0;
        got_order = "";
        done = 1'b0;
        @(posedge clk);
        #1;
        if_req = 1'b1; if_addr = 32'h500;
        d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h400; d_size = 2'b10; d_sign = 1'b0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (d_valid) got_order = {got_order, "D"};
            if (if_valid) got_order = {got_order, "I"};
            if (got_order.len() >= 10) begin
                done = 1'b1;
                break;
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        if (!done) chk("timeout_contention", 32'd0, 32'd1);
        n_cmp++;
        if (got_order != exp_order) begin
            n_fail++;
            $display("FAIL grant_order: got %s, expected %s", got_order, exp_order);
        end

        // Reset while a load waits on memory, then re-arbitration of the held request.
        wait_cycles = 100;
        @(posedge clk);
        #1;
        d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h300; d_size = 2'b10; d_sign = 1'b0;
        done = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (m_req) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("timeout_rst_mreq", 32'd0, 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        @(posedge clk);
        #1;
        chk("rst_no_dvalid", 32'(d_valid), 32'd0);
        push_exp(mk_exp(1'b1, 1'b0, 32'h300, 32'h0, 2'b10, 1'b0));
        wait_cycles = 0;
        rst_n = 1'b1;
        res_lat = 0;
        done = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            res_lat++;
            if (d_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("timeout_rearb", 32'd0, 32'd1);
        chk("rearb_lat", res_lat, 32'd2);
        chk("rearb_rdata", d_rdata, 32'h8001_FFFE);
        d_req = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("cq_drained", cq.size(), 32'd0);
        chk("mq_drained", mq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
